// File: rtl/parking_gate_sensor_if.sv
// Gate sensor bundle: raw beams and spot/full inputs in, car pulses and gate status out.
interface parking_gate_sensor_if;
  logic       beam_a;
  logic       beam_b;
  logic [1:0] spot_sel;
  logic       garage_full;
  logic       car_in;
  logic       car_out;
  logic [1:0] Ex;
  logic       gate_open;
  logic       busy;
  logic       fault;

  modport master (
    output beam_a, beam_b, spot_sel, garage_full,
    input  car_in, car_out, Ex, gate_open, busy, fault
  );

  modport slave (
    input  beam_a, beam_b, spot_sel, garage_full,
    output car_in, car_out, Ex, gate_open, busy, fault
  );
endinterface

// File: rtl/parking_gate_sensor.sv
// Gate front end: synchronises and debounces two light beams, decodes entry/exit
// order into one-cycle car_in/car_out pulses with the spot id, and drives the barrier.
module parking_gate_sensor #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5,
  parameter int TO_CYCLES = 4096,
  parameter int TO_W      = 13
) (
  input  logic                 clk_in,
  input  logic                 RST,
  parking_gate_sensor_if.slave gs
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IN_A   = 3'd1;
  localparam logic [2:0] S_IN_AB  = 3'd2;
  localparam logic [2:0] S_IN_B   = 3'd3;
  localparam logic [2:0] S_OUT_B  = 3'd4;
  localparam logic [2:0] S_OUT_BA = 3'd5;
  localparam logic [2:0] S_OUT_A  = 3'd6;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  // bit 1 = beam A (outer), bit 0 = beam B (inner)
  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];

  logic [2:0]      state;
  logic [2:0]      state_n;
  logic [TO_W-1:0] to_cnt;
  logic            reject_q;
  logic [1:0]      spot_q;
  logic            pulse_in;
  logic            pulse_out;
  logic            timeout;

  // Stage p0/p1: two-flop synchroniser, then per-beam stability counter
  always_ff @(posedge clk_in) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= {gs.beam_a, gs.beam_b};
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Only a single forward step advances; any other pattern change abandons the pass.
  always_comb begin
    state_n   = state;
    pulse_in  = 1'b0;
    pulse_out = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (db == 2'b10)      state_n = S_IN_A;
        else if (db == 2'b01) state_n = S_OUT_B;
      end
      S_IN_A: begin
        if (reject_q) begin
          if (db == 2'b00) state_n = S_IDLE;
        end else if (db == 2'b11) begin
          state_n = S_IN_AB;
        end else if (db != 2'b10) begin
          state_n = S_IDLE;
        end
      end
      S_IN_AB: begin
        if (db == 2'b01)      state_n = S_IN_B;
        else if (db != 2'b11) state_n = S_IDLE;
      end
      S_IN_B: begin
        if (db != 2'b01) state_n = S_IDLE;
        if (db == 2'b00) pulse_in = 1'b1;
      end
      S_OUT_B: begin
        if (db == 2'b11)      state_n = S_OUT_BA;
        else if (db != 2'b01) state_n = S_IDLE;
      end
      S_OUT_BA: begin
        if (db == 2'b10)      state_n = S_OUT_A;
        else if (db != 2'b11) state_n = S_IDLE;
      end
      S_OUT_A: begin
        if (db != 2'b10) state_n = S_IDLE;
        if (db == 2'b00) pulse_out = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE && state_n == state && to_cnt == TO_LAST) begin
      state_n = S_IDLE;
      timeout = 1'b1;
    end
  end

  // Stage p2: state, timeout and registered outputs
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state        <= S_IDLE;
      to_cnt       <= '0;
      reject_q     <= 1'b0;
      gs.car_in    <= 1'b0;
      gs.car_out   <= 1'b0;
      gs.Ex        <= 2'b00;
      gs.gate_open <= 1'b0;
      gs.busy      <= 1'b0;
      gs.fault     <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state || state == S_IDLE) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + 1'b1;
      if (state == S_IDLE && state_n == S_IN_A) reject_q <= gs.garage_full;
      gs.car_in  <= pulse_in;
      gs.car_out <= pulse_out;
      if (pulse_in || pulse_out) gs.Ex <= spot_q;
      gs.gate_open <= ((state == S_IN_A || state == S_IN_AB || state == S_IN_B) && !reject_q)
                   || state == S_OUT_B || state == S_OUT_BA || state == S_OUT_A;
      gs.busy <= (state != S_IDLE);
      if (timeout) gs.fault <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (state == S_IDLE && state_n != S_IDLE) spot_q <= gs.spot_sel;
  end

endmodule
